// File: rtl/soc_status_regs_pkg.sv
// rtl/soc_status_regs_pkg.sv - shared constants and types for the status/control register block
// Purpose: register word indices, STATUS bit positions, handshake FSM encoding
//          and default parameter values used by soc_status_regs and led_blinker.
// Ports:   none (package).
package soc_status_regs_pkg;

  localparam logic [2:0] REG_HALT    = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_CYCLE   = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_LEDDIV  = 3'd4;

  localparam int STATUS_HALTED_BIT   = 0;
  localparam int STATUS_DSP_DONE_BIT = 1;

  localparam logic [31:0] HALT_SIG_DEFAULT   = 32'hDEAD_BEEF;
  localparam logic [15:0] LEDDIV_RST_DEFAULT = 16'd24999;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/soc_status_regs_led_blinker.sv
// rtl/soc_status_regs_led_blinker.sv - LED blinker that runs only while the CPU is halted
// Purpose: holds the LED off while running; once halted, toggles the LED every
//          leddiv+1 cycles.
// Ports:   clock, reset (sync, active-high), halted (in), leddiv[15:0] (in),
//          led_o (out, registered).
module led_blinker
  import soc_status_regs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        halted,
  input  logic [15:0] leddiv,
  output logic        led_o
);

  logic [15:0] blink_cnt;

  always_ff @(posedge clock) begin
    if (reset || !halted) begin
      blink_cnt <= '0;
      led_o     <= 1'b0;
    end else if (blink_cnt >= leddiv) begin
      // >= rather than == so that lowering leddiv mid-count cannot strand the
      // counter above the new limit for a full 16-bit wrap.
      blink_cnt <= '0;
      led_o     <= ~led_o;
    end else begin
      blink_cnt <= blink_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/soc_status_regs.sv
// rtl/soc_status_regs.sv - memory-mapped halt/status/cycle-counter responder on the CPU data bus
// Purpose: latches the CPU halt signature and DSP-done events, runs a cycle
//          counter, exposes a scratch register and drives a halt-blink LED.
// Ports:   clock, reset (sync, active-high)
//          req_valid_i/req_ready_o/req_we_i/req_addr_i[2:0]/req_wdata_i[31:0] - request
//          rsp_valid_o/rsp_ready_i/rsp_rdata_o[31:0] - read response
//          dsp_done_i (in pulse), cpu_halted_o (out), led_o (out)
module soc_status_regs
  import soc_status_regs_pkg::*;
#(
  parameter logic [31:0] HALT_SIG   = HALT_SIG_DEFAULT,
  parameter logic [15:0] LEDDIV_RST = LEDDIV_RST_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  input  logic        dsp_done_i,
  output logic        cpu_halted_o,
  output logic        led_o
);

  state_t      state;
  logic        halted;
  logic        dsp_done;
  logic [31:0] scratch;
  logic [31:0] cycle_cnt;
  logic [15:0] leddiv;
  logic [31:0] rd_data;
  logic        accept;
  logic        wr_en;
  logic        rd_en;

  assign accept       = req_valid_i && (state == ST_IDLE);
  assign wr_en        = accept && req_we_i;
  assign rd_en        = accept && !req_we_i;
  assign req_ready_o  = (state == ST_IDLE);
  assign rsp_valid_o  = (state == ST_RESP);
  assign cpu_halted_o = halted;

  // Read mux sees pre-edge register values, so a read accepted on the same
  // edge as a state change returns the old value.
  always_comb begin
    rd_data = '0;
    case (req_addr_i)
      REG_HALT:    rd_data = halted ? HALT_SIG : 32'd0;
      REG_SCRATCH: rd_data = scratch;
      REG_CYCLE:   rd_data = cycle_cnt;
      REG_STATUS: begin
        rd_data[STATUS_HALTED_BIT]   = halted;
        rd_data[STATUS_DSP_DONE_BIT] = dsp_done;
      end
      REG_LEDDIV:  rd_data = {16'd0, leddiv};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      halted      <= 1'b0;
      dsp_done    <= 1'b0;
      scratch     <= '0;
      cycle_cnt   <= '0;
      leddiv      <= LEDDIV_RST;
      rsp_rdata_o <= '0;
    end else begin
      // Counter still advances on the halting edge itself; it freezes from the
      // first cycle in which halted is visible.
      if (!halted) cycle_cnt <= cycle_cnt + 32'd1;

      if (wr_en) begin
        case (req_addr_i)
          REG_HALT:    if (req_wdata_i == HALT_SIG) halted <= 1'b1;
          REG_SCRATCH: scratch <= req_wdata_i;
          REG_LEDDIV:  leddiv  <= req_wdata_i[15:0];
          default:     ;
        endcase
      end

      // A done pulse beats a same-cycle write-1-to-clear so no event is lost.
      if (dsp_done_i)
        dsp_done <= 1'b1;
      else if (wr_en && req_addr_i == REG_STATUS && req_wdata_i[STATUS_DSP_DONE_BIT])
        dsp_done <= 1'b0;

      case (state)
        ST_IDLE: if (rd_en) begin
          rsp_rdata_o <= rd_data;
          state       <= ST_RESP;
        end
        ST_RESP: if (rsp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  led_blinker u_led_blinker (
    .clock  (clock),
    .reset  (reset),
    .halted (halted),
    .leddiv (leddiv),
    .led_o  (led_o)
  );

endmodule

// File: tb/tb_soc_status_regs.sv
// tb/tb_soc_status_regs.sv - self-checking bench for soc_status_regs
module tb_soc_status_regs;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        dsp_done_i = 1'b0;
  logic        cpu_halted_o;
  logic        led_o;

  localparam logic [31:0] SIG = 32'hDEADBEEF;

  soc_status_regs dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .dsp_done_i   (dsp_done_i),
    .cpu_halted_o (cpu_halted_o),
    .led_o        (led_o)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];
  logic [31:0] last_rdata;

  // Reference cycle counter / halt flag driven from the bus stimulus.
  logic [31:0] m_cycle;
  logic        m_halted;
  always @(posedge clock) begin
    if (reset) begin
      m_cycle  <= '0;
      m_halted <= 1'b0;
    end else begin
      if (!m_halted) m_cycle <= m_cycle + 32'd1;
      if (req_valid_i && req_we_i && req_ready_o && req_addr_i == 3'd0 && req_wdata_i == SIG)
        m_halted <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expected value per completed response handshake.
  always @(negedge clock) begin
    if (!reset && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_rdata_o);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, rsp_rdata_o, e.exp);
        last_rdata = rsp_rdata_o;
      end
    end
  end

  task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = data;
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      tests++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    sb.push_back('{exp: exp, name: name});
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = addr;
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    wait_drain(name);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        use_model;
    string       name;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    vecs.push_back('{we: 0, addr: 3'd0, data: 32'h0,        use_model: 0, name: "rst_halt"});
    vecs.push_back('{we: 0, addr: 3'd1, data: 32'h0,        use_model: 0, name: "rst_scratch"});
    vecs.push_back('{we: 0, addr: 3'd2, data: 32'h0,        use_model: 1, name: "rst_cycle"});
    vecs.push_back('{we: 0, addr: 3'd3, data: 32'h0,        use_model: 0, name: "rst_status"});
    vecs.push_back('{we: 0, addr: 3'd4, data: 32'd24999,    use_model: 0, name: "rst_leddiv"});
    vecs.push_back('{we: 0, addr: 3'd5, data: 32'h0,        use_model: 0, name: "unmapped5"});
    vecs.push_back('{we: 0, addr: 3'd6, data: 32'h0,        use_model: 0, name: "unmapped6"});
    vecs.push_back('{we: 0, addr: 3'd7, data: 32'h0,        use_model: 0, name: "unmapped7"});
    vecs.push_back('{we: 0, addr: 3'd2, data: 32'h0,        use_model: 1, name: "cycle_again"});
    vecs.push_back('{we: 1, addr: 3'd5, data: 32'hFFFFFFFF, use_model: 0, name: "wr_unmapped"});
    vecs.push_back('{we: 0, addr: 3'd5, data: 32'h0,        use_model: 0, name: "unmapped5_wr"});
    vecs.push_back('{we: 1, addr: 3'd2, data: 32'h55,       use_model: 0, name: "wr_cycle"});
    vecs.push_back('{we: 0, addr: 3'd2, data: 32'h0,        use_model: 1, name: "cycle_ro"});
    vecs.push_back('{we: 1, addr: 3'd1, data: 32'hA5A55A5A, use_model: 0, name: "wr_scratch"});
    vecs.push_back('{we: 0, addr: 3'd1, data: 32'hA5A55A5A, use_model: 0, name: "scratch_rb"});
    vecs.push_back('{we: 1, addr: 3'd4, data: 32'h00012345, use_model: 0, name: "wr_leddiv"});
    vecs.push_back('{we: 0, addr: 3'd4, data: 32'h00002345, use_model: 0, name: "leddiv_rb"});
    vecs.push_back('{we: 1, addr: 3'd0, data: 32'h12345678, use_model: 0, name: "wr_badhalt"});
    vecs.push_back('{we: 0, addr: 3'd0, data: 32'h0,        use_model: 0, name: "halt_bad_rd"});
    vecs.push_back('{we: 1, addr: 3'd4, data: 32'h3,        use_model: 0, name: "wr_leddiv3"});
    vecs.push_back('{we: 0, addr: 3'd4, data: 32'h3,        use_model: 0, name: "leddiv3_rb"});

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_halted", {31'd0, cpu_halted_o}, 32'd0);
    check("rst_led", {31'd0, led_o}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].use_model ? m_cycle : vecs[i].data, vecs[i].name);
    end
    check("halted_after_badsig", {31'd0, cpu_halted_o}, 32'd0);

    // DSP done: sticky set, set beats same-cycle clear, write-1-to-clear.
    dsp_done_i = 1'b1;
    @(posedge clock);
    #1;
    dsp_done_i = 1'b0;
    do_read(3'd3, 32'h2, "status_dsp_set");
    dsp_done_i = 1'b1;
    do_write(3'd3, 32'h2);
    dsp_done_i = 1'b0;
    do_read(3'd3, 32'h2, "status_set_wins");
    do_write(3'd3, 32'h0);
    do_read(3'd3, 32'h2, "status_wr0_keeps");
    do_write(3'd3, 32'h2);
    do_read(3'd3, 32'h0, "status_cleared");

    // Response back-pressure: held response, second request waits.
    rsp_ready_i = 1'b0;
    sb.push_back('{exp: 32'hA5A55A5A, name: "stall_rsp"});
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 3'd1;
    @(posedge clock);
    #1;
    req_addr_i  = 3'd4;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
      check("stall_rdata", rsp_rdata_o, 32'hA5A55A5A);
      if (i < 4) begin
        @(posedge clock);
        #1;
      end
    end
    rsp_ready_i = 1'b1;
    sb.push_back('{exp: 32'h3, name: "stall_second_rsp"});
    @(posedge clock);
    #1;
    check("stall_release_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    wait_drain("stall_second");

    // Halt with LEDDIV=3: halted next cycle, LED toggles every 4 cycles, CYCLE frozen.
    do_write(3'd0, SIG);
    check("halted_rise", {31'd0, cpu_halted_o}, 32'd1);
    check("led_at_halt", {31'd0, led_o}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("led_k%0d", k), {31'd0, led_o}, (k / 4) % 2);
    end
    do_read(3'd2, m_cycle, "cycle_halted1");
    c1 = last_rdata;
    repeat (10) @(posedge clock);
    #1;
    do_read(3'd2, m_cycle, "cycle_halted2");
    c2 = last_rdata;
    check("cycle_frozen", c2, c1);
    do_read(3'd0, SIG, "halt_rd_sig");
    do_read(3'd3, 32'h1, "status_halted");

    // DSP done arriving while a response is pending still registers.
    rsp_ready_i = 1'b0;
    sb.push_back('{exp: 32'hA5A55A5A, name: "resp_dsp_rsp"});
    req_valid_i = 1'b1;
    req_addr_i  = 3'd1;
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    dsp_done_i  = 1'b1;
    @(posedge clock);
    #1;
    dsp_done_i  = 1'b0;
    rsp_ready_i = 1'b1;
    wait_drain("resp_dsp");
    do_read(3'd3, 32'h3, "status_dsp_in_resp");

    // Reset while a response is held.
    rsp_ready_i = 1'b0;
    sb.push_back('{exp: 32'hA5A55A5A, name: "dropped_rsp"});
    req_valid_i = 1'b1;
    req_addr_i  = 3'd1;
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    check("pre_reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    check("mid_reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("mid_reset_halted", {31'd0, cpu_halted_o}, 32'd0);
    check("mid_reset_led", {31'd0, led_o}, 32'd0);
    check("mid_reset_ready", {31'd0, req_ready_o}, 32'd1);
    reset = 1'b0;
    rsp_ready_i = 1'b1;
    do_read(3'd1, 32'h0, "post_reset_scratch");
    do_read(3'd4, 32'd24999, "post_reset_leddiv");
    do_read(3'd3, 32'h0, "post_reset_status");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/soc_status_regs.md
# soc_status_regs

Memory-mapped status/control responder on the CPU data bus, decoded by the bus interconnect alongside data memory and the DSP. The CPU program signals completion by writing the halt signature to a dedicated register instead of a data-memory word, so board status needs no hierarchical probing. The block latches halt and DSP-done events, runs a cycle counter, and drives a board LED (steady-off while running, blinking once halted).

## Interface
- HALT_SIG, 32'hDEADBEEF, value that sets the halted flag when written to HALT
- LEDDIV_RST, 16'd24999, reset value of LEDDIV
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid_i  in  1  bus request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  3  word index of register
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  read data valid
- rsp_ready_i  in  1  interconnect accepts read data
- rsp_rdata_o  out  32  read data
- dsp_done_i  in  1  single-cycle done pulse from DSP
- cpu_halted_o  out  1  halted flag
- led_o  out  1  LED drive

## Operation
- Register map (word index): 0 HALT, 1 SCRATCH, 2 CYCLE, 3 STATUS, 4 LEDDIV, 5–7 unmapped (read 0, writes ignored).
- HALT: a write of exactly HALT_SIG sets halted (sticky until reset); other values are ignored. Reads return HALT_SIG if halted, else 0.
- SCRATCH: 32-bit read/write register.
- CYCLE: read-only 32-bit counter.
  - Increments every cycle while not halted and wraps 0xFFFFFFFF→0.
  - Freezes starting in the cycle after halted sets.
  - Writes are ignored.
- STATUS: bit0 halted (read-only), bit1 dsp_done (sticky).
  - dsp_done_i sets bit1. Writing 1 to bit1 clears it; writing 0 leaves it unchanged.
  - If a set and a clear occur in the same cycle, the set wins.
  - Bits 31:2 read 0.
- LEDDIV: bits 15:0 read/write; bits 31:16 read 0.
- Handshake FSM, two states:
  - IDLE: req_ready_o=1. On req_valid_i with req_we_i=1, the write commits at that edge, no response is generated, and the FSM stays in IDLE. On req_valid_i with req_we_i=0, the register is sampled into rsp_rdata_o at that edge and the FSM goes to RESP.
  - RESP: rsp_valid_o=1, req_ready_o=0, rsp_rdata_o held stable. On rsp_ready_i the FSM returns to IDLE.
- LED blinker: 16-bit counter blink_cnt.
  - While not halted: blink_cnt=0 and led_o=0.
  - While halted: blink_cnt increments each cycle. When blink_cnt >= LEDDIV, blink_cnt←0 and led_o toggles, so the half-period is LEDDIV+1 cycles.
  - The >= compare handles LEDDIV being lowered mid-count.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, cpu_halted_o=0, led_o=0, SCRATCH=0, CYCLE=0, STATUS=0, LEDDIV=LEDDIV_RST, FSM=IDLE.
- Read latency: rsp_valid_o rises 1 cycle after acceptance. Throughput is at most one read per 2 cycles (rsp_ready_i tied high). Back-to-back writes are accepted every cycle.
- A write is visible to a read accepted in the following cycle.
- cpu_halted_o rises in the cycle after the HALT_SIG write edge. A CYCLE read accepted at that write edge returns the pre-write count.
- The first led_o toggle occurs LEDDIV+1 cycles after cpu_halted_o rises.
- dsp_done_i arriving in RESP still sets bit1. A dsp_done_i pulse is never lost.
- reset mid-RESP: the response is dropped and rsp_valid_o=0 next cycle. The interconnect must also reset.

## Structure
- Shared package: register index constants (REG_HALT..REG_LEDDIV), STATUS bit positions, FSM state encoding, default HALT_SIG.
- One sub-module, led_blinker (halted, LEDDIV in; led_o out). Everything else stays flat.

## Test plan
- Reset, then read all 8 indices → HALT=0, SCRATCH=0, STATUS=0, LEDDIV=24999, indices 5–7 = 0, CYCLE nonzero and increasing across two reads.
- Write SCRATCH=0xA5A55A5A, read back → 0xA5A55A5A. Write HALT=0x12345678 → cpu_halted_o stays 0.
- Write LEDDIV=3, write HALT=0xDEADBEEF → cpu_halted_o=1 next cycle, led_o toggles every 4 cycles, CYCLE reads the same value twice 10 cycles apart, HALT reads 0xDEADBEEF.
- Pulse dsp_done_i → STATUS=0x2. Write STATUS=0x2 in the same cycle as a dsp_done_i pulse → STATUS stays 0x2. Write 0x2 alone → STATUS=0x0.
- Read with rsp_ready_i held low 5 cycles → rsp_valid_o=1 and req_ready_o=0 for 5 cycles, rsp_rdata_o stable, and a second request is not accepted until release.
- Assert reset during RESP → next cycle rsp_valid_o=0, cpu_halted_o=0, led_o=0, SCRATCH=0.
